// File: rtl/menu_pkg.sv
// Shared definitions for the menu screen: the controller state encoding,
// default button geometry (screen pixels) and the colours the menu pixel
// generator uses to draw the buttons and the connect status.
package menu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LINK  = 3'd2,
    S_START = 3'd3,
    S_GAME  = 3'd4
  } state_e;

  // Button rectangles: X0/Y0 inclusive, X1/Y1 exclusive.
  localparam int unsigned BTN_X0_DEF       = 220;
  localparam int unsigned BTN_X1_DEF       = 420;
  localparam int unsigned START_Y0_DEF     = 250;
  localparam int unsigned START_Y1_DEF     = 300;
  localparam int unsigned CONN_Y0_DEF      = 320;
  localparam int unsigned CONN_Y1_DEF      = 370;
  localparam int unsigned CONN_TIMEOUT_DEF = 500000000;  // 5 s at 100 MHz

  // 12-bit RGB colours shared with the menu pixel generator.
  localparam logic [11:0] COL_BG        = 12'h000;
  localparam logic [11:0] COL_BTN       = 12'h444;
  localparam logic [11:0] COL_BTN_HOVER = 12'h888;
  localparam logic [11:0] COL_TEXT      = 12'hFFF;
  localparam logic [11:0] COL_CONN_WAIT = 12'hFA0;
  localparam logic [11:0] COL_CONN_LINK = 12'h0F0;

endpackage

// File: rtl/menu_button_click.sv
// One menu button: rectangle hit test on registered cursor coordinates, and
// press/release-to-click conversion.
//   clk, rst_n   clock, synchronous active-low reset
//   x_i, y_i     registered cursor position
//   rise_i       left button press edge (aligned with x_i/y_i)
//   fall_i       left button release edge (aligned with x_i/y_i)
//   en_i         1 while in the menu; 0 forces hover off and disarms
//   hover_o      cursor inside the rectangle and enabled
//   click_o      1-cycle pulse: released over the button after pressing on it
module menu_button_click
  import menu_pkg::*;
#(
  parameter int unsigned X0 = BTN_X0_DEF,
  parameter int unsigned X1 = BTN_X1_DEF,
  parameter int unsigned Y0 = START_Y0_DEF,
  parameter int unsigned Y1 = START_Y1_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic       rise_i,
  input  logic       fall_i,
  input  logic       en_i,
  output logic       hover_o,
  output logic       click_o
);

  localparam logic [9:0] X0_L = 10'(X0);
  localparam logic [9:0] X1_L = 10'(X1);
  localparam logic [9:0] Y0_L = 10'(Y0);
  localparam logic [9:0] Y1_L = 10'(Y1);

  logic hit;
  logic armed_q, armed_d;

  assign hit     = (x_i >= X0_L) && (x_i < X1_L) && (y_i >= Y0_L) && (y_i < Y1_L);
  assign hover_o = hit && en_i;
  assign click_o = armed_q && fall_i && hover_o;

  // Leaving the button (or the menu) while held drops the arm, so a later
  // release back over the button does not count.
  always_comb begin
    armed_d = armed_q;
    if (!hover_o)    armed_d = 1'b0;
    else if (rise_i) armed_d = 1'b1;
    else if (fall_i) armed_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= armed_d;
  end

endmodule

// File: rtl/menu_ctrl.sv
// Menu-screen controller: START/CONNECT hover and click detection, two-board
// connect handshake with timeout, and the start-game pulse.
//   clk, rst_n               clock, synchronous active-low reset
//   mouse_x, mouse_y         cursor position (registered here, 1-cycle latency)
//   MOUSE_LEFT               left button level
//   peer_connect             peer's send_connect (asynchronous, 2-FF synchronised)
//   game_exit                1-cycle pulse from the game FSM: back to menu
//   mouse_on_start_button    hover START (menu only)
//   mouse_on_connect_button  hover CONNECT (menu only)
//   send_connect             local connect request
//   receive_connect          synchronised peer_connect
//   start_game               1-cycle pulse on leaving the menu
//   multiplayer              1 if linked when START was clicked
//   in_menu                  1 outside S_GAME
//   dbg_state_o              current controller state
module menu_ctrl
  import menu_pkg::*;
#(
  parameter int unsigned BTN_X0       = BTN_X0_DEF,
  parameter int unsigned BTN_X1       = BTN_X1_DEF,
  parameter int unsigned START_Y0     = START_Y0_DEF,
  parameter int unsigned START_Y1     = START_Y1_DEF,
  parameter int unsigned CONN_Y0      = CONN_Y0_DEF,
  parameter int unsigned CONN_Y1      = CONN_Y1_DEF,
  parameter int unsigned CONN_TIMEOUT = CONN_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       MOUSE_LEFT,
  input  logic       peer_connect,
  input  logic       game_exit,
  output logic       mouse_on_start_button,
  output logic       mouse_on_connect_button,
  output logic       send_connect,
  output logic       receive_connect,
  output logic       start_game,
  output logic       multiplayer,
  output logic       in_menu,
  output state_e     dbg_state_o
);

  localparam logic [28:0] TMO_LAST = 29'(CONN_TIMEOUT - 1);

  logic [9:0]  x_q, y_q;
  logic        left_q, left_prev_q;
  logic        sync1_q, sync2_q;
  logic        rise, fall;
  logic        start_click, conn_click;
  state_e      state_q, state_d;
  logic        mp_q, mp_d;
  logic [28:0] timer_q, timer_d;

  // During reset the button history tracks the live level, so a button
  // already held when reset is released is not seen as a fresh press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      left_q      <= MOUSE_LEFT;
      left_prev_q <= MOUSE_LEFT;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
    end else begin
      x_q         <= mouse_x;
      y_q         <= mouse_y;
      left_q      <= MOUSE_LEFT;
      left_prev_q <= left_q;
      sync1_q     <= peer_connect;
      sync2_q     <= sync1_q;
    end
  end

  assign rise            = left_q && !left_prev_q;
  assign fall            = !left_q && left_prev_q;
  assign receive_connect = sync2_q;
  assign in_menu         = (state_q != S_GAME);

  menu_button_click #(
    .X0(BTN_X0), .X1(BTN_X1), .Y0(START_Y0), .Y1(START_Y1)
  ) u_start_btn (
    .clk(clk), .rst_n(rst_n), .x_i(x_q), .y_i(y_q), .rise_i(rise), .fall_i(fall),
    .en_i(in_menu), .hover_o(mouse_on_start_button), .click_o(start_click)
  );

  menu_button_click #(
    .X0(BTN_X0), .X1(BTN_X1), .Y0(CONN_Y0), .Y1(CONN_Y1)
  ) u_conn_btn (
    .clk(clk), .rst_n(rst_n), .x_i(x_q), .y_i(y_q), .rise_i(rise), .fall_i(fall),
    .en_i(in_menu), .hover_o(mouse_on_connect_button), .click_o(conn_click)
  );

  // A CONNECT click beats an arriving peer; an arriving peer beats timeout.
  always_comb begin
    state_d = state_q;
    mp_d    = mp_q;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (conn_click) begin
          state_d = S_WAIT;
          timer_d = '0;
        end else if (start_click) begin
          state_d = S_START;
          mp_d    = 1'b0;
        end
      end
      S_WAIT: begin
        if (conn_click) begin
          state_d = S_IDLE;
        end else if (start_click) begin
          state_d = S_START;
          mp_d    = 1'b0;
        end else if (receive_connect) begin
          state_d = S_LINK;
        end else if (timer_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 29'd1;
        end
      end
      S_LINK: begin
        if (conn_click) begin
          state_d = S_IDLE;
        end else if (start_click) begin
          state_d = S_START;
          mp_d    = 1'b1;
        end else if (!receive_connect) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_START: state_d = S_GAME;
      S_GAME: begin
        if (game_exit) begin
          state_d = S_IDLE;
          mp_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mp_q    <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      mp_q    <= mp_d;
      timer_q <= timer_d;
    end
  end

  assign start_game   = (state_q == S_START);
  assign multiplayer  = mp_q;
  assign send_connect = (state_q == S_WAIT) || (state_q == S_LINK) ||
                        (((state_q == S_START) || (state_q == S_GAME)) && mp_q);
  assign dbg_state_o  = state_q;

endmodule
